// File: rtl/captura_pkg.sv
// Shared definitions for the capture buffer: FSM state encoding,
// buffer depth and default datapath widths.
package captura_pkg;

  localparam int CAPTURA_DATA_W = 32;
  localparam int CAPTURA_ADDR_W = 14;
  localparam int CAPTURA_DEPTH  = 16384;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READOUT = 2'd2
  } captura_state_t;

endpackage

// File: rtl/ram_dp_captura.sv
// Simple dual-port RAM for the capture buffer: synchronous write port and
// registered read port, written so synthesis maps it onto block RAM.
// No reset on the array or on the read register.
module ram_dp_captura #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port: the sample lands in the array on the edge that samples we.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: the output register updates only on a read, so it holds between reads.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/captura_buffer_ram.sv
// Stream-to-RAM capture block. A trigger in IDLE starts recording a fixed
// number of valid samples into the buffer. A reader then drains the buffer
// in order with rd_req / rd_valid. done marks the last word.
// Optional build macro CAPTURA_DECIMACION_EN adds the decim input. With it,
// only every (decim+1)-th valid sample is stored, starting with the first.
module captura_buffer_ram
  import captura_pkg::*;
#(
  parameter int DATA_W = CAPTURA_DATA_W,
  parameter int ADDR_W = CAPTURA_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              trigger,
  input  logic [ADDR_W:0]   n_samples,
`ifdef CAPTURA_DECIMACION_EN
  input  logic [7:0]        decim,
`endif
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              full,
  output logic              done
);

  // Pointers carry one extra bit so a full-depth length never aliases to 0.
  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};

  captura_state_t    state, state_nxt;
  logic [ADDR_W:0]   len, wr_ptr, rd_ptr;
  logic              take_trig, wr_fire, rd_fire, last_rd, keep;
  logic              rd_seen_p1;
  logic [DATA_W-1:0] ram_q_p1;

  // A length of 0 or anything beyond the buffer means "fill the whole buffer".
  function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] n);
    if (n == '0 || n > DEPTH_LEN) return DEPTH_LEN;
    else                          return n;
  endfunction

`ifdef CAPTURA_DECIMACION_EN
  logic [7:0] decim_q, dec_cnt;

  // Decimation phase: store only when the valid-sample counter is at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      decim_q <= '0;
      dec_cnt <= '0;
    end else if (take_trig) begin
      decim_q <= decim;
      dec_cnt <= '0;
    end else if (state == CAPTURE && data_valid) begin
      dec_cnt <= (dec_cnt == decim_q) ? 8'd0 : dec_cnt + 8'd1;
    end
  end

  assign keep = (dec_cnt == 8'd0);
`else
  assign keep = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, write/read strobes and status flags.
  always_comb begin
    state_nxt = state;
    take_trig = 1'b0;
    wr_fire   = 1'b0;
    rd_fire   = 1'b0;
    last_rd   = 1'b0;
    busy      = 1'b0;
    full      = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          take_trig = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        busy = 1'b1;
        if (data_valid && keep) begin
          wr_fire = 1'b1;
          if (wr_ptr == len - PTR_ONE) state_nxt = READOUT;
        end
      end
      READOUT: begin
        full = 1'b1;
        if (rd_req && (rd_ptr < len)) begin
          rd_fire = 1'b1;
          if (rd_ptr == len - PTR_ONE) begin
            last_rd   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture length and write/read pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (take_trig) begin
        len    <= sat_len(n_samples);
        wr_ptr <= '0;
        rd_ptr <= '0;
      end
      if (wr_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Read handshake, aligned with the RAM read register.
  // rd_seen_p1 masks the unreset RAM output until a read has happened.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid   <= 1'b0;
      done       <= 1'b0;
      rd_seen_p1 <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      done     <= last_rd;
      if (rd_fire) rd_seen_p1 <= 1'b1;
    end
  end

  assign rd_data = rd_seen_p1 ? ram_q_p1 : '0;

  ram_dp_captura #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (data_in),
    .re    (rd_fire),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (ram_q_p1)
  );

endmodule

// File: tb/tb_captura_buffer_ram.sv
// Scoreboard bench for captura_buffer_ram: readout requests push expected
// words into a queue, and a monitor pops and compares on each rd_valid.
module tb_captura_buffer_ram;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        trigger = 1'b0;
  logic [14:0] n_samples = '0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid, busy, full, done;
`ifdef CAPTURA_DECIMACION_EN
  logic [7:0]  decim = '0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic        dn;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_vals[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  captura_buffer_ram dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .trigger    (trigger),
    .n_samples  (n_samples),
`ifdef CAPTURA_DECIMACION_EN
    .decim      (decim),
`endif
    .rd_req     (rd_req),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .full       (full),
    .done       (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [14:0] n);
    n_samples = n;
    trigger   = 1'b1;
    tick();
    trigger   = 1'b0;
  endtask

  task automatic push_sample(input logic [31:0] v);
    data_in    = v;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  // Issue back-to-back requests for the words queued in exp_vals.
  task automatic readout(input string nm);
    int n;
    n = exp_vals.size();
    for (int i = 0; i < n; i++) begin
      rd_req = 1'b1;
      sb.push_back('{d: exp_vals[i], dn: (i == n - 1)});
      tick();
    end
    rd_req = 1'b0;
    exp_vals.delete();
    tick();
    tick();
    check({nm, "_drain"}, sb.size(), 0);
    check({nm, "_idle_full"}, {31'd0, full}, 32'd0);
    check({nm, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rd_valid) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_rd_valid actual=%0h required=none", rd_data);
          end else begin
            e = sb.pop_front();
            if (rd_data !== e.d || done !== e.dn) begin
              n_err++;
              $display("FAIL rd_word actual=%0h/done=%0b required=%0h/done=%0b",
                       rd_data, done, e.d, e.dn);
            end
          end
        end else if (done) begin
          n_vec++;
          n_err++;
          $display("FAIL done_without_valid actual=1 required=0");
        end
      end
    end
  endtask

  task automatic stimulus();
    // Reset state
    tick();
    tick();
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_flags", {28'd0, rd_valid, busy, full, done}, 32'd0);
    reset = 1'b0;
    tick();

    // Ramp 0..7, full buffer readout
    start(15'd8);
    check("t1_busy_rise", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) push_sample(i);
    check("t1_full", {30'd0, busy, full}, 32'd1);
    for (int i = 0; i < 8; i++) exp_vals.push_back(i);
    readout("t1");

    // Toggling valid: only 10,12,14,16 stored
    start(15'd4);
    for (int i = 0; i < 7; i++) begin
      data_in    = 32'd10 + i;
      data_valid = (i % 2 == 0);
      tick();
      if (i == 4) check("t2_full_early", {31'd0, full}, 32'd0);
    end
    data_valid = 1'b0;
    check("t2_full_after4", {31'd0, full}, 32'd1);
    exp_vals = '{32'd10, 32'd12, 32'd14, 32'd16};
    readout("t2");

    // rd_req in IDLE, trigger and rd_req during CAPTURE are ignored
    rd_req = 1'b1;
    tick();
    tick();
    tick();
    rd_req = 1'b0;
    check("t4_idle_rdvld", {31'd0, rd_valid}, 32'd0);
    start(15'd4);
    push_sample(32'd100);
    push_sample(32'd101);
    trigger   = 1'b1;
    rd_req    = 1'b1;
    n_samples = 15'd2;
    tick();
    trigger = 1'b0;
    rd_req  = 1'b0;
    check("t4_busy_kept", {31'd0, busy}, 32'd1);
    check("t4_cap_rdvld", {31'd0, rd_valid}, 32'd0);
    push_sample(32'd102);
    check("t4_not_full", {31'd0, full}, 32'd0);
    push_sample(32'd103);
    check("t4_full", {31'd0, full}, 32'd1);
    exp_vals = '{32'd100, 32'd101, 32'd102, 32'd103};
    readout("t4");

    // Reset mid-capture, then short recapture
    start(15'd8);
    push_sample(32'h55);
    push_sample(32'h56);
    push_sample(32'h57);
    reset = 1'b1;
    #1;
    check("t5_rst_rd_data", rd_data, 32'd0);
    check("t5_rst_flags", {28'd0, rd_valid, busy, full, done}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t5_idle", {30'd0, busy, full}, 32'd0);
    start(15'd2);
    push_sample(32'hAAAA_0001);
    push_sample(32'hBBBB_0002);
    check("t5_full", {31'd0, full}, 32'd1);
    exp_vals = '{32'hAAAA_0001, 32'hBBBB_0002};
    readout("t5");

    // n_samples = 0 means the whole 16384-word buffer
    start(15'd0);
    for (int i = 0; i < 16384; i++) begin
      push_sample(i);
      if (i == 16382) check("t3_full_early", {31'd0, full}, 32'd0);
    end
    check("t3_full", {31'd0, full}, 32'd1);
    for (int i = 0; i < 16384; i++) exp_vals.push_back(i);
    readout("t3");

`ifdef CAPTURA_DECIMACION_EN
    // Decimation by 3 on a ramp 0..11
    decim = 8'd2;
    start(15'd4);
    decim = 8'd0;
    for (int i = 0; i < 12; i++) push_sample(i);
    check("t6_full", {31'd0, full}, 32'd1);
    exp_vals = '{32'd0, 32'd3, 32'd6, 32'd9};
    readout("t6");
`endif
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/captura_buffer_ram.md
# captura_buffer_ram

Stream-to-RAM capture block and the write-side counterpart of the lookup-table data sources. On a trigger it records a fixed number of valid 32-bit samples from a processing-chain stream into an on-chip buffer of 16384 words. It then lets a host-side reader drain the buffer sequentially with a request/valid handshake. It sits at the end of the signal chain, before the readout or transfer logic.

## Interface
- `DATA_W`, 32, sample width.
- `ADDR_W`, 14, buffer address width; depth = 2^ADDR_W = 16384.
- `clk` in 1: single system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `data_in` in DATA_W: sample stream.
- `data_valid` in 1: `data_in` is valid this cycle.
- `trigger` in 1: starts a capture; level-sampled, acted on only in IDLE.
- `n_samples` in ADDR_W+1: capture length, range 1..16384. It is latched at trigger. A value of 0 or above 16384 is treated as 16384.
- `rd_req` in 1: reader requests the next stored word.
- `rd_data` out DATA_W: read word.
- `rd_valid` out 1: `rd_data` is valid; one-cycle pulse.
- `busy` out 1: high in CAPTURE.
- `full` out 1: high in READOUT; the buffer holds a complete capture.
- `done` out 1: one-cycle pulse when the last word has been read.

## Operation
- FSM states: IDLE, CAPTURE, READOUT.
- IDLE → CAPTURE when `trigger` is high.
  - `n_samples` is latched into `len`; `wr_ptr` and `rd_ptr` are set to 0.
  - If `data_valid` is high in the trigger cycle, that sample is not stored. Capture starts on the following cycle.
- CAPTURE:
  - Each cycle with `data_valid` high writes `data_in` to `mem[wr_ptr]` and increments `wr_ptr`.
  - A low `data_valid` pauses the capture and loses nothing.
  - When the write of index `len-1` occurs, the FSM goes to READOUT on the next edge.
  - `trigger` is ignored.
- READOUT:
  - `rd_req` high with `rd_ptr < len` reads `mem[rd_ptr]` and increments `rd_ptr`.
  - The read for index `len-1` also pulses `done` together with its `rd_valid`, then returns to IDLE.
  - `data_valid` and `trigger` are ignored.
- `rd_req` outside READOUT is ignored; `rd_valid` stays low.
- Pointer width is ADDR_W+1, so a length of 16384 causes no wrap ambiguity. The memory address is `ptr[ADDR_W-1:0]`.
- `reset` at any time forces IDLE and clears the pointers, `len`, and all outputs. Memory contents are not cleared. A new trigger overwrites the buffer from index 0.
- Reset values: `rd_data` = 0, `rd_valid` = 0, `busy` = 0, `full` = 0, `done` = 0.

## Timing
- Write: the sample is in memory on the edge at which `data_valid` is sampled high.
- Read latency:
  - `rd_req` sampled high at edge k → `rd_data` and `rd_valid` registered at edge k+1.
  - `rd_data` holds its value until the next read.
- Back-to-back `rd_req` gives one word per cycle.
- `busy` rises one cycle after `trigger` is sampled. `busy` falls and `full` rises on the edge after the last write.
- `full` falls in the same cycle that `done` pulses.
- Throughput: one sample per clock in both directions.

## Configuration
- Macro: `CAPTURA_DECIMACION_EN`.
- When defined:
  - An extra input `decim` [7:0] is added and latched at trigger.
  - During CAPTURE, a decimation counter counts valid samples. Only every (`decim`+1)-th valid sample is stored, starting with the first.
  - `decim` = 0 stores every sample.
- When undefined: the `decim` port and counter do not exist, and every valid sample is stored.

## Structure
- Shared package `captura_pkg` holds:
  - State encoding `captura_state_t` (IDLE=0, CAPTURE=1, READOUT=2).
  - `CAPTURA_DEPTH` = 16384.
  - Default widths.
- Sub-module `ram_dp_captura`: a simple dual-port RAM with a synchronous write port and a registered read port, inferring block RAM. The FSM, pointers, and handshake stay in the top module.

## Test plan
- Reset, then trigger with `n_samples`=8 and a ramp 0..7 with `data_valid` always high. After `full`, issue 8 back-to-back `rd_req` → `rd_data` = 0..7 on consecutive cycles, `done` pulses with value 7, state returns to IDLE.
- Capture 4 samples with `data_valid` toggling 1,0,1,0 on a ramp 10..17 → stored values are 10, 12, 14, 16, and `full` rises only after the 4th valid sample.
- `n_samples`=0 with a 16384-word ramp → readout returns 0..16383, and `done` pulses after exactly 16384 reads.
- Assert `trigger` during CAPTURE and `rd_req` during CAPTURE or IDLE → no effect on pointers, and `rd_valid` stays 0.
- Assert `reset` after 3 of 8 samples → outputs are 0 and state is IDLE. Retrigger with 2 samples A and B → readout gives A, B.
- With `CAPTURA_DECIMACION_EN` defined and `decim`=2, a ramp 0..11 with `n_samples`=4 → readout gives 0, 3, 6, 9.
